// File: rtl/multi_clock_divider_pkg.sv
// multi_clock_divider_pkg: shared helpers for the programmable divider.
// Reset half-period, write-select width and counter-fit check.
package multi_clock_divider_pkg;

  function automatic longint unsigned h0_calc(
    input longint unsigned clk_hz,
    input longint unsigned freq_hz
  );
    return clk_hz / (2 * freq_hz);
  endfunction

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit h0_fits(
    input longint unsigned h0,
    input int w
  );
    if (w >= 64) return 1'b1;
    return (h0 >> w) == 0;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// clock_divider_channel: one 50%-duty divider with tick strobe.
// Half-period changes are staged in pending and applied at boundaries.
module clock_divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int              CNT_WIDTH = 27,
  parameter logic [CNT_WIDTH-1:0] H0   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ld,
  input  logic [CNT_WIDTH-1:0] ld_val,
  output logic                 clk_out,
  output logic                 tick
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  cnt_t cnt_q, cnt_d;
  cnt_t act_q, act_d;
  cnt_t pend_q, pend_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;

  // Next-state: stage writes, run/stop/idle the counter, toggle on boundary.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = ld ? ld_val : pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      clk_d = 1'b0;
      act_d = pend_q;
    end else if (act_q == '0) begin
      cnt_d = '0;
      act_d = pend_q;
    end else if (cnt_q >= act_q - ONE) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      act_d  = pend_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // State registers; reset wins over enable and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      act_q  <= H0;
      pend_q <= H0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N independent programmable clock dividers.
// Decodes the half-period write port and replicates the channel.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_WIDTH    = 27,
  parameter longint      DEFAULT_CLK  = 100000000,
  parameter longint      DEFAULT_FREQ = 1,
  localparam int         WR_W         = clog2_min1(CHANNELS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CHANNELS-1:0]  i_en,
  input  logic                 i_wr_en,
  input  logic [WR_W-1:0]      i_wr_ch,
  input  logic [CNT_WIDTH-1:0] i_wr_div,
  output logic [CHANNELS-1:0]  o_clk,
  output logic [CHANNELS-1:0]  o_tick
);

  localparam longint unsigned H0L =
    h0_calc(longint'(DEFAULT_CLK), longint'(DEFAULT_FREQ));
  localparam logic [CNT_WIDTH-1:0] H0 = CNT_WIDTH'(H0L);

  if (!h0_fits(H0L, CNT_WIDTH)) begin : g_h0_too_wide
    $error("reset half-period does not fit in CNT_WIDTH");
  end

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be 1..16");
  end

  logic [CHANNELS-1:0] ld;

  // One-hot write decode; out-of-range channel numbers hit nothing.
  always_comb begin
    ld = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_wr_en && (int'(i_wr_ch) == c)) ld[c] = 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    clock_divider_channel #(
      .CNT_WIDTH(CNT_WIDTH),
      .H0       (H0)
    ) u_ch (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (i_en[c]),
      .ld     (ld[c]),
      .ld_val (i_wr_div),
      .clk_out(o_clk[c]),
      .tick   (o_tick[c])
    );
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- N-channel programmable clock divider. Successor to the fixed single-output divider in the FPGA board designs.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe, so counters and displays such as the stopwatch can use either.
- Each channel's half-period is reloadable at runtime through a simple write port.
- Sits between the board oscillator domain logic and timekeeping, display-refresh and debounce blocks. All outputs are synchronous to i_clk.

Parameters:
- CHANNELS, 4: number of independent divider channels (1..16).
- CNT_WIDTH, 27: width of the counter and half-period registers.
- DEFAULT_CLK, 100000000: input clock frequency in Hz.
- DEFAULT_FREQ, 1: reset output frequency of every channel in Hz.
  - Reset half-period H0 = DEFAULT_CLK/(2*DEFAULT_FREQ).
  - H0 must fit in CNT_WIDTH; otherwise elaboration fails via a generate-time error.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  CHANNELS  per-channel run enable.
- i_wr_en  in  1  half-period write strobe.
- i_wr_ch  in  clog2(CHANNELS), min 1  target channel of the write.
- i_wr_div  in  CNT_WIDTH  new half-period H, in i_clk cycles.
- o_clk  out  CHANNELS  divided clocks.
- o_tick  out  CHANNELS  one-cycle strobe per divided-clock rising edge.

Behaviour:
- Reset (i_rst=1 at a rising edge of i_clk), per channel:
  - counter=0, o_clk=0, o_tick=0.
  - active_H=H0, pending_H=H0.
  - Reset overrides writes and enables in the same cycle.
  - Reset mid-period abandons the period; there is no glitch beyond a forced low.
- Write: i_wr_en=1 with i_wr_ch<CHANNELS sets pending_H[i_wr_ch]=i_wr_div on that edge.
  - i_wr_ch>=CHANNELS is ignored.
  - Writes never touch the counter or o_clk directly.
- Channel disabled (i_en[c]=0):
  - counter<=0, o_clk<=0, o_tick<=0.
  - active_H<=pending_H, so the new value applies immediately on re-enable.
- Channel enabled, active_H=0:
  - Channel is stopped: counter=0, o_clk holds its current value, o_tick=0.
  - active_H<=pending_H every cycle, so a nonzero write restarts the channel.
- Channel enabled, active_H>=1:
  - If counter>=active_H-1: counter<=0, o_clk<=~o_clk, active_H<=pending_H (half-period boundary).
  - Otherwise counter<=counter+1.
  - The >= compare is defensive only.
- Divided clock timing:
  - Period = 2*active_H cycles, 50% duty.
  - The first toggle after enable occurs on the active_H-th enabled edge.
  - active_H=1 gives i_clk/2.
- o_tick[c]=1 for exactly one cycle, registered, on the same edge where o_clk[c] goes 0->1. Otherwise 0.
- Write on a boundary cycle: the boundary loads the old pending_H. The new value takes effect at the following boundary (no bypass).
- Rate change latency: at most one half-period. A change never truncates a half-period in progress.
- Counter wrap: cannot occur; counter is bounded by active_H-1 <= 2^CNT_WIDTH-2.
- Channels are fully independent. Simultaneous boundaries on several channels are all honoured.

Decomposition:
- Package multi_clock_divider_pkg holds:
  - the H0 computation function;
  - the clog2 helper for the i_wr_ch width;
  - a CNT_WIDTH-fit check constant.
- Sub-module clock_divider_channel implements one channel:
  - ports: clk, rst, en, ld (decoded write), ld_val, clk_out, tick;
  - registers: counter, active_H, pending_H.
- The top level decodes i_wr_ch and generates CHANNELS instances.

Test Plan:
All scenarios use CHANNELS=2, CNT_WIDTH=8, DEFAULT_CLK=8, DEFAULT_FREQ=1, so H0=4.
- Reset, then i_en=2'b01 held -> o_clk[0] rises at enabled edge 4, falls at 8, period 8 cycles; o_tick[0] high only on the rise edges; channel 1 stays 0.
- Write ch1 H=1 while disabled, then enable -> o_clk[1] toggles every cycle (i_clk/2); o_tick[1] pulses every 2nd cycle.
- Ch0 running H=4, write H=2 mid-high-phase -> current half-period completes at 4 cycles; subsequent half-periods are 2 cycles; no short pulse.
- Write H=0 to ch0 while running, then H=3 -> ch0 freezes at its level after the next boundary, no ticks; after the H=3 write it resumes with a 6-cycle period.
- i_wr_ch=3 (out of range) with H=7 -> no channel's period changes.
- Assert i_rst mid-period with writes pending -> next cycle all o_clk=0, o_tick=0; after release, period is back to H0 (8 cycles).
